// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Load/store front end for a word-addressed data memory: alignment/range    |
// | checks, sign/zero-extended loads and read-modify-write sub-word stores.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

  localparam logic [31:0] c_addr_limit = 32'(MEM_WORDS * 4);

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        w_req_err;
  logic [31:0] w_merge;

  assign w_req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | (req_addr >= c_addr_limit);

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Sub-word stores patch the word fetched in RD; word stores bypass the buffer.
  always_comb begin
    w_merge = r_buf;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'b00: w_merge[7:0]   = r_wdata[7:0];
          2'b01: w_merge[15:8]  = r_wdata[7:0];
          2'b10: w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE) & ~reset;
  assign mem_read  = (r_state == ST_RD) & ~reset;
  assign mem_write = (r_state == ST_WR) & ~reset;
  assign mem_addr  = ((r_state == ST_RD) || (r_state == ST_WR)) ? {r_addr[31:2], 2'b00} : 32'b0;
  assign mem_wdata = (r_state == ST_WR) ? w_merge : 32'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= 32'b0;
      r_wdata    <= 32'b0;
      r_buf      <= 32'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_state    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              r_state <= ST_RD;
            end else if (req_size == 2'b10) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_buf <= mem_rdata;
          if (r_write) begin
            r_state <= ST_WR;
          end else begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= extract(mem_rdata, r_size, r_signed, r_addr[1:0]);
          end
        end
        ST_WR: begin
          r_state    <= ST_RESP;
          resp_valid <= 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
